// File: rtl/fixed_to_pcm.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | fixed_to_pcm: fixed-point to PCM rescale, round, saturate, output FIFO   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fixed_to_pcm #(
  parameter int fractional_size = 12,
  parameter int operand_size    = 32,
  parameter int sample_size     = 16,
  parameter int fifo_depth      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [operand_size-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [sample_size-1:0]  out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    clip_clear,
  output logic                    clip_flag,
  output logic [15:0]             clip_count
);

  localparam int D  = sample_size - 1 - fractional_size;
  localparam int AD = (D < 0) ? -D : D;
  localparam int W  = operand_size + AD + 1;
  localparam int AW = $clog2(fifo_depth);
  localparam logic [AW+1:0] DEPTH_V = fifo_depth[AW+1:0];

  logic [W-1:0] ext;
  logic [W-1:0] scaled;

  assign ext = {{(AD+1){in_data[operand_size-1]}}, in_data};

  generate
    if (D >= 0) begin : g_shift_left
      assign scaled = ext << AD;
    end else begin : g_round_right
      localparam logic [W-1:0] HALF = {{(W-1){1'b0}}, 1'b1} << (AD - 1);
      logic [W-1:0] sum;
      assign sum    = ext + HALF;
      assign scaled = $signed(sum) >>> AD;
    end
  endgenerate

  logic         s1_valid;
  logic [W-1:0] s1_data;
  logic [AW:0]  wr_ptr;
  logic [AW:0]  wr_vis;
  logic [AW:0]  rd_ptr;
  logic [AW:0]  occ;
  logic         accept;
  logic         rd;

  assign occ      = wr_ptr - rd_ptr;
  assign in_ready = rst_n && (({1'b0, occ} + {{(AW+1){1'b0}}, s1_valid}) < DEPTH_V);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_data <= scaled;
    end
  end

  // In range iff every bit from the PCM sign bit upward matches the MSB.
  logic                   clip_hi;
  logic                   clip_lo;
  logic                   clip_evt;
  logic [sample_size-1:0] sat;

  assign clip_hi  = !s1_data[W-1] &&  (|s1_data[W-2:sample_size-1]);
  assign clip_lo  =  s1_data[W-1] && !(&s1_data[W-2:sample_size-1]);
  assign clip_evt = s1_valid && (clip_hi || clip_lo);
  assign sat      = clip_hi ? {1'b0, {(sample_size-1){1'b1}}} :
                    clip_lo ? {1'b1, {(sample_size-1){1'b0}}} :
                    s1_data[sample_size-1:0];

  logic [sample_size-1:0] mem [fifo_depth];

  always_ff @(posedge clk) begin
    if (s1_valid) mem[wr_ptr[AW-1:0]] <= sat;
  end

  // wr_vis lags wr_ptr by one cycle so a written entry becomes visible one edge later.
  assign out_valid = (wr_vis != rd_ptr);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign rd        = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      wr_vis <= '0;
      rd_ptr <= '0;
    end else begin
      if (s1_valid) wr_ptr <= wr_ptr + 1'b1;
      wr_vis <= wr_ptr;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_flag  <= 1'b0;
      clip_count <= 16'd0;
    end else if (clip_evt) begin
      clip_flag <= 1'b1;
      if (clip_clear)                clip_count <= 16'd1;
      else if (clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
    end else if (clip_clear) begin
      clip_flag  <= 1'b0;
      clip_count <= 16'd0;
    end
  end

endmodule
`default_nettype wire
